// File: rtl/nrisc_reg_ctx_seq.sv
// nrisc_reg_ctx_seq: register-context save/restore sequencer for the NRISC
// register file. Save walks R2..R15, reads each selected register through
// ctx_RF/ctx_rdata and writes it to base_addr+n. Restore reads base_addr+n
// from memory and writes it back through ctx_RFD/ctx_D/ctx_Write.
// Optional build macro: NRISC_CTX_TIMEOUT_EN (bounded memory wait, err flag).
module nrisc_reg_ctx_seq #(
    parameter int TAM     = 16,
    parameter int TIMEOUT = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_save,
    input  logic           start_restore,
    input  logic [TAM-1:0] base_addr,
    input  logic [15:0]    reg_mask,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [3:0]     ctx_RF,
    input  logic [TAM-1:0] ctx_rdata,
    output logic [3:0]     ctx_RFD,
    output logic [TAM-1:0] ctx_D,
    output logic           ctx_Write,
    output logic [TAM-1:0] mem_addr,
    output logic [TAM-1:0] mem_wdata,
    input  logic [TAM-1:0] mem_rdata,
    output logic           mem_wr,
    output logic           mem_rd,
    input  logic           mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_SAVE_WR, S_RST_RD, S_RST_WB, S_DONE
    } state_t;

    state_t         state_q;
    logic [3:0]     idx_q;
    logic           restore_q;   // 0 = save, 1 = restore
    logic [TAM-1:0] base_q;
    logic [15:0]    mask_q;

    logic           busy_q, done_q, ctx_Write_q, mem_wr_q, mem_rd_q;
    logic [3:0]     ctx_RF_q, ctx_RFD_q;
    logic [TAM-1:0] ctx_D_q, mem_addr_q, mem_wdata_q;

    // Next index and the frame address that goes with it (wraps modulo 2^TAM).
    logic [3:0]     idx_d;
    logic [TAM-1:0] addr_d;
    logic           last_idx;

    assign idx_d    = idx_q + 4'd1;
    assign addr_d   = base_q + {{(TAM-4){1'b0}}, idx_d};
    assign last_idx = (idx_q == 4'd15);

`ifdef NRISC_CTX_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wcnt_q;
    logic          err_q;
    logic          tmo;
    // Wait limit hits on the cycle that would make the TIMEOUT-th stalled cycle.
    assign tmo = (wcnt_q == CW'(TIMEOUT - 1));
    assign err = err_q;
`else
    logic tmo;
    assign tmo = 1'b0;
    // Unbounded wait: err can never be raised; TIMEOUT has no effect here.
    assign err = (TIMEOUT < 0);
`endif

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            restore_q   <= 1'b0;
            base_q      <= '0;
            mask_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ctx_RF_q    <= 4'd0;
            ctx_RFD_q   <= 4'd0;
            ctx_D_q     <= '0;
            ctx_Write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
`ifdef NRISC_CTX_TIMEOUT_EN
            wcnt_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            done_q      <= 1'b0;
            ctx_Write_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_save || start_restore) begin
                        restore_q  <= ~start_save;   // save has priority
                        base_q     <= base_addr;
                        mask_q     <= reg_mask;
                        idx_q      <= 4'd2;
                        ctx_RF_q   <= 4'd2;
                        mem_addr_q <= base_addr + TAM'(2);
                        busy_q     <= 1'b1;
`ifdef NRISC_CTX_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
`ifdef NRISC_CTX_TIMEOUT_EN
                    wcnt_q <= '0;
`endif
                    if (mask_q[idx_q]) begin
                        if (!restore_q) begin
                            mem_wdata_q <= ctx_rdata;
                            mem_wr_q    <= 1'b1;
                            state_q     <= S_SAVE_WR;
                        end else begin
                            mem_rd_q    <= 1'b1;
                            state_q     <= S_RST_RD;
                        end
                    end else if (last_idx) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q      <= idx_d;
                        ctx_RF_q   <= idx_d;
                        mem_addr_q <= addr_d;
                    end
                end
                S_SAVE_WR: begin
                    if (mem_ready) begin
                        mem_wr_q <= 1'b0;
                        if (last_idx) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q      <= idx_d;
                            ctx_RF_q   <= idx_d;
                            mem_addr_q <= addr_d;
                            state_q    <= S_SCAN;
                        end
                    end else if (tmo) begin
                        mem_wr_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
`ifdef NRISC_CTX_TIMEOUT_EN
                        err_q    <= 1'b1;
`endif
                        state_q  <= S_DONE;
                    end else begin
`ifdef NRISC_CTX_TIMEOUT_EN
                        wcnt_q <= wcnt_q + 1'b1;
`endif
                    end
                end
                S_RST_RD: begin
                    if (mem_ready) begin
                        mem_rd_q    <= 1'b0;
                        ctx_D_q     <= mem_rdata;
                        ctx_RFD_q   <= idx_q;
                        ctx_Write_q <= 1'b1;
                        state_q     <= S_RST_WB;
                    end else if (tmo) begin
                        // Timed-out read: no write-back, remaining registers skipped.
                        mem_rd_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
`ifdef NRISC_CTX_TIMEOUT_EN
                        err_q    <= 1'b1;
`endif
                        state_q  <= S_DONE;
                    end else begin
`ifdef NRISC_CTX_TIMEOUT_EN
                        wcnt_q <= wcnt_q + 1'b1;
`endif
                    end
                end
                S_RST_WB: begin
                    if (last_idx) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q      <= idx_d;
                        ctx_RF_q   <= idx_d;
                        mem_addr_q <= addr_d;
                        state_q    <= S_SCAN;
                    end
                end
                S_DONE: begin
                    // Starts are deliberately not looked at here.
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ctx_RF    = ctx_RF_q;
    assign ctx_RFD   = ctx_RFD_q;
    assign ctx_D     = ctx_D_q;
    assign ctx_Write = ctx_Write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;

endmodule

// File: doc/nrisc_reg_ctx_seq.md
Name: nrisc_reg_ctx_seq

Overview:
Register-context save/restore sequencer that sits on the other side of the NRISC register file from the core.
- Save: reads a masked subset of R2..R15 through a read-select/read-data pair and writes each value to memory.
- Restore: reads memory and drives the register-file write port (RFD/D/Write).
- The interrupt/ISR entry-exit logic uses it to spill or refill the register context while the core is stalled.
- Bank selection (USR/FIRQ) is not controlled here; it follows the core's interrupt flag.

Parameters:
TAM, 16, data/address width (matches the register-file width)
TIMEOUT, 256, memory wait limit in cycles (used only with NRISC_CTX_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-low reset
start_save  input  1  begin save sequence (sampled in IDLE only)
start_restore  input  1  begin restore sequence (sampled in IDLE only)
base_addr  input  TAM  memory base of the context frame (sampled at start)
reg_mask  input  16  bit n set = transfer Rn (sampled at start; bits 0,1 ignored)
busy  output  1  sequence in progress
done  output  1  one-cycle completion pulse
err  output  1  timeout flag, valid with done
ctx_RF  output  4  register read select (to REG_RF1-style port)
ctx_rdata  input  TAM  register read data (combinational from register file)
ctx_RFD  output  4  register write index
ctx_D  output  TAM  register write data
ctx_Write  output  1  register write strobe
mem_addr  output  TAM  memory address
mem_wdata  output  TAM  memory write data
mem_rdata  input  TAM  memory read data, valid when mem_ready=1
mem_wr  output  1  memory write request
mem_rd  output  1  memory read request
mem_ready  input  1  memory acknowledge

Behaviour:
Reset and start:
- Reset (rst=0 at a clk edge): state IDLE; all outputs 0 (ctx_RF, ctx_RFD, ctx_D, mem_addr, mem_wdata included).
- Reset mid-operation aborts immediately. No further mem_wr, mem_rd or ctx_Write; no done pulse.
- IDLE: if start_save=1, latch base_addr, reg_mask and mode=save, then go to SCAN with idx=2. Else if start_restore=1, same with mode=restore.
- Save wins when start_save and start_restore are both 1.
- Starts are ignored in every state other than IDLE.

Cycle numbering: cycle 1 is the first cycle after the start edge.

SCAN (busy=1), one cycle per index:
- ctx_RF=idx, mem_addr=base+idx, computed modulo 2^TAM (wraps).
- If mask[idx]=1 and mode=save: latch ctx_rdata into mem_wdata, go to SAVE_WR.
- If mask[idx]=1 and mode=restore: go to RST_RD.
- Otherwise: if idx=15 go to DONE, else idx+1.

SAVE_WR:
- mem_wr=1, mem_addr and mem_wdata held stable until mem_ready=1 is sampled.
- Then mem_wr drops and the FSM goes to SCAN idx+1, or to DONE if idx=15.

RST_RD:
- mem_rd=1 until mem_ready=1; capture mem_rdata into ctx_D on that edge, then go to RST_WB.

RST_WB:
- ctx_Write=1 for exactly one cycle, with ctx_RFD=idx and ctx_D=captured value.
- Then go to SCAN idx+1, or DONE if idx=15.

DONE:
- busy=0, done=1 for one cycle, then IDLE.
- A start is not accepted in the DONE cycle.

Timing and invariants:
- Latency: an empty mask gives done in cycle 15.
- Each saved register adds 1+W cycles; each restored register adds 2+W cycles (W = wait cycles with mem_ready=0).
- mem_ready sampled outside SAVE_WR/RST_RD is ignored.
- mem_wr and mem_rd are never high together.
- ctx_Write is never high outside RST_WB.
- R0 and R1 are never read or written.

Optional Feature:
Macro NRISC_CTX_TIMEOUT_EN.
- Defined:
  - An 8+ bit wait counter clears on entering SAVE_WR/RST_RD and increments each cycle while mem_ready=0.
  - On reaching TIMEOUT it drops the request and goes to DONE, where err=1 together with done.
  - Remaining registers are skipped and no ctx_Write is issued for the timed-out read.
- Undefined: the FSM waits indefinitely; err is tied to 0.

Test Plan:
- Save, mask=0x000C, base=0x0100, R2=0x1111, R3=0x2222, zero-wait memory -> mem writes 0x0102<-0x1111 (cycle 2) and 0x0103<-0x2222 (cycle 4); done in cycle 17; no ctx_Write.
- Restore, mask=0x8000, base=0x0200, memory returns 0xBEEF after 3 wait cycles -> mem_rd at 0x020F for 4 cycles; one ctx_Write with RFD=15, D=0xBEEF; done in cycle 20.
- Mask=0x0003 -> no mem or ctx_Write activity, done in cycle 15. Base=0xFFFF with mask=0x0004 save -> mem_addr=0x0001 (wrap).
- start_save=start_restore=1 in the same cycle -> save sequence runs. A start pulse while busy=1 -> ignored; exactly one done.
- rst=0 during SAVE_WR with mem_ready=0 -> next cycle all outputs 0, busy=0, done never pulses, no later mem_wr.
- mem_ready held 0 in save, mask=0x0004 -> with NRISC_CTX_TIMEOUT_EN: done=1 and err=1 after 256 wait cycles. Without it: busy stays 1 and mem_wr stays 1 for 1000 cycles.
